alu_arbiter: RTL and testbench

Shares one combinational N-bit ALU between two requesters (r0, r1) using round-robin arbitration. Each request (op select, operand A, operand B) uses a valid/ready handshake. The block registers the operands, drives the ALU, captures the result and returns it on a per-requester response channel with its own valid/ready handshake. It sits between two client datapaths and a single ALU instance, with 4-bit op-select encoding passed through unchanged.

---
 rtl/alu_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered, the ALU result is captured one cycle later and held until the owner accepts it.
module alu_arbiter #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             r0_valid_i,
    output logic             r0_ready_o,
    input  logic [3:0]       r0_op_sel_i,
    input  logic [N-1:0]     r0_op_a_i,
    input  logic [N-1:0]     r0_op_b_i,
    output logic             r0_rsp_valid_o,
    output logic [N-1:0]     r0_rsp_data_o,
    input  logic             r0_rsp_ready_i,
    input  logic             r1_valid_i,
    output logic             r1_ready_o,
    input  logic [3:0]       r1_op_sel_i,
    input  logic [N-1:0]     r1_op_a_i,
    input  logic [N-1:0]     r1_op_b_i,
    output logic             r1_rsp_valid_o,
    output logic [N-1:0]     r1_rsp_data_o,
    input  logic             r1_rsp_ready_i,
    output logic [3:0]       alu_op_sel_o,
    output logic [N-1:0]     alu_op_a_o,
    output logic [N-1:0]     alu_op_b_o,
    input  logic [N-1:0]     alu_res_i,
    output logic             busy_o,
    output logic             owner_o,
    output logic [CNT_W-1:0] op_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    logic             owner_reg;
    logic             last_grant_reg;
    logic [3:0]       op_reg;
    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_reg;
    logic [N-1:0]     res_reg;
    logic [CNT_W-1:0] op_count_reg;

    logic [1:0] req_valid;
    logic [1:0] grant;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;

    assign req_valid = {r1_valid_i, r0_valid_i};
    assign rsp_ready = {r1_rsp_ready_i, r0_rsp_ready_i};

    // On a tie the requester that was not served last wins.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign grant[gi]     = req_valid[gi] &
                                   (!req_valid[1-gi] || (last_grant_reg != 1'(gi)));
            assign req_ready[gi] = (state_reg == IDLE) && grant[gi] && !rst_i;
            assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi)) && !rst_i;
        end
    endgenerate

    assign r0_ready_o     = req_ready[0];
    assign r1_ready_o     = req_ready[1];
    assign r0_rsp_valid_o = rsp_valid[0];
    assign r1_rsp_valid_o = rsp_valid[1];
    assign r0_rsp_data_o  = res_reg;
    assign r1_rsp_data_o  = res_reg;

    assign alu_op_sel_o = op_reg;
    assign alu_op_a_o   = a_reg;
    assign alu_op_b_o   = b_reg;
    assign busy_o       = (state_reg != IDLE);
    assign owner_o      = owner_reg;
    assign op_count_o   = op_count_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            res_reg        <= '0;
            op_count_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_ready[1]) begin
                        op_reg    <= r1_op_sel_i;
                        a_reg     <= r1_op_a_i;
                        b_reg     <= r1_op_b_i;
                        owner_reg <= 1'b1;
                        state_reg <= EXEC;
                    end else if (req_ready[0]) begin
                        op_reg    <= r0_op_sel_i;
                        a_reg     <= r0_op_a_i;
                        b_reg     <= r0_op_b_i;
                        owner_reg <= 1'b0;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    res_reg   <= alu_res_i;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_reg]) begin
                        last_grant_reg <= owner_reg;
                        op_count_reg   <= op_count_reg + 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small reference ALU attached.
module tb_alu_arbiter;

    localparam int N = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
    logic [3:0]       r0_op;
    logic [N-1:0]     r0_a, r0_b, r0_rsp_data;
    logic             r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
    logic [3:0]       r1_op;
    logic [N-1:0]     r1_a, r1_b, r1_rsp_data;
    logic [3:0]       alu_op;
    logic [N-1:0]     alu_a, alu_b, alu_res;
    logic             busy, owner;
    logic [CNT_W-1:0] op_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 signed less-than.
    always_comb begin
        alu_res = 32'hDEAD_BEEF;
        case (alu_op)
            4'd0: alu_res = alu_a + alu_b;
            4'd1: alu_res = alu_a - alu_b;
            4'd2: alu_res = alu_a & alu_b;
            4'd3: alu_res = alu_a | alu_b;
            4'd4: alu_res = alu_a ^ alu_b;
            4'd5: alu_res = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_res = 32'hDEAD_BEEF;
        endcase
    end

    alu_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_op_sel_i(r0_op),
        .r0_op_a_i(r0_a), .r0_op_b_i(r0_b), .r0_rsp_valid_o(r0_rsp_valid),
        .r0_rsp_data_o(r0_rsp_data), .r0_rsp_ready_i(r0_rsp_ready),
        .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_op_sel_i(r1_op),
        .r1_op_a_i(r1_a), .r1_op_b_i(r1_b), .r1_rsp_valid_o(r1_rsp_valid),
        .r1_rsp_data_o(r1_rsp_data), .r1_rsp_ready_i(r1_rsp_ready),
        .alu_op_sel_o(alu_op), .alu_op_a_o(alu_a), .alu_op_b_o(alu_b),
        .alu_res_i(alu_res), .busy_o(busy), .owner_o(owner), .op_count_o(op_count)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction from requester r with rsp_ready held high.
    task automatic run_txn(input int r, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input string tag);
        int n;
        if (r == 0) begin
            r0_op = op; r0_a = a; r0_b = b; r0_valid = 1'b1; r0_rsp_ready = 1'b1;
        end else begin
            r1_op = op; r1_a = a; r1_b = b; r1_valid = 1'b1; r1_rsp_ready = 1'b1;
        end
        #1;
        n = 0;
        while (((r == 0) ? r0_ready : r1_ready) !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'((r == 0) ? r0_ready : r1_ready), 32'd1);
        tick();
        r0_valid = (r == 0) ? 1'b0 : r0_valid;
        r1_valid = (r == 1) ? 1'b0 : r1_valid;
        tick();
        chk({tag, "_rspv"}, 32'((r == 0) ? r0_rsp_valid : r1_rsp_valid), 32'd1);
        chk({tag, "_data"}, (r == 0) ? r0_rsp_data : r1_rsp_data, exp);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        r0_valid = 1'b1; r0_op = 4'd0; r0_a = '0; r0_b = '0; r0_rsp_ready = 1'b0;
        r1_valid = 1'b1; r1_op = 4'd0; r1_a = '0; r1_b = '0; r1_rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'({r1_ready, r0_ready}), 32'd0);
        chk("rst_rspv", 32'({r1_rsp_valid, r0_rsp_valid}), 32'd0);
        r0_valid = 1'b0; r1_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);

        // Single SUM with latency checks
        r0_op = 4'd0; r0_a = 32'd5; r0_b = 32'd3; r0_valid = 1'b1; r0_rsp_ready = 1'b1;
        #1;
        chk("sum_ready", 32'({r1_ready, r0_ready}), 32'd1);
        tick();
        r0_valid = 1'b0;
        chk("sum_alu_a", alu_a, 32'd5);
        chk("sum_exec_busy", 32'(busy), 32'd1);
        chk("sum_exec_rspv", 32'(r0_rsp_valid), 32'd0);
        tick();
        chk("sum_rspv", 32'({r1_rsp_valid, r0_rsp_valid}), 32'd1);
        chk("sum_data", r0_rsp_data, 32'd8);
        tick();
        chk("sum_busy", 32'(busy), 32'd0);
        chk("sum_count", 32'(op_count), 32'd1);

        // Tie right after reset: r0 first, r1 waits
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r0_op = 4'd1; r0_a = 32'd10; r0_b = 32'd4; r0_valid = 1'b1; r0_rsp_ready = 1'b1;
        r1_op = 4'd2; r1_a = 32'hF0F0F0F0; r1_b = 32'h0FF00FF0; r1_valid = 1'b1; r1_rsp_ready = 1'b1;
        #1;
        chk("tie_ready", 32'({r1_ready, r0_ready}), 32'd1);
        tick();
        r0_valid = 1'b0;
        chk("tie_exec_r1rdy", 32'(r1_ready), 32'd0);
        tick();
        chk("tie_r0_data", r0_rsp_data, 32'h6);
        chk("tie_resp_r1rdy", 32'(r1_ready), 32'd0);
        tick();
        chk("tie_r1_ready", 32'({r1_ready, r0_ready}), 32'd2);
        tick();
        r1_valid = 1'b0;
        chk("tie_owner", 32'(owner), 32'd1);
        tick();
        chk("tie_r1_rspv", 32'({r1_rsp_valid, r0_rsp_valid}), 32'd2);
        chk("tie_r1_data", r1_rsp_data, 32'h00F000F0);
        tick();
        chk("tie_count", 32'(op_count), 32'd2);

        // Both hold valid: six alternating grants, one every 3 cycles
        r0_op = 4'd0; r0_a = 32'd1;    r0_b = 32'd2;    r0_valid = 1'b1;
        r1_op = 4'd3; r1_a = 32'h10;   r1_b = 32'h01;   r1_valid = 1'b1;
        for (int k = 0; k < 18; k++) begin
            #1;
            if (k % 3 == 0)
                chk($sformatf("rr_ready_%0d", k), 32'({r1_ready, r0_ready}),
                    ((k / 3) % 2 == 0) ? 32'd1 : 32'd2);
            else
                chk($sformatf("rr_ready_%0d", k), 32'({r1_ready, r0_ready}), 32'd0);
            if (k % 3 == 2) begin
                chk($sformatf("rr_rspv_%0d", k), 32'({r1_rsp_valid, r0_rsp_valid}),
                    ((k / 3) % 2 == 0) ? 32'd1 : 32'd2);
                chk($sformatf("rr_data_%0d", k), r0_rsp_data,
                    ((k / 3) % 2 == 0) ? 32'h3 : 32'h11);
            end
            tick();
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        chk("rr_count", 32'(op_count), 32'd8);

        // Response back-pressure on r1 with r0 waiting
        r1_op = 4'd5; r1_a = 32'd3; r1_b = 32'd5; r1_valid = 1'b1; r1_rsp_ready = 1'b0;
        #1;
        chk("bp_r1_ready", 32'({r1_ready, r0_ready}), 32'd2);
        tick();
        r1_valid = 1'b0;
        r0_op = 4'd0; r0_a = 32'd7; r0_b = 32'd1; r0_valid = 1'b1; r0_rsp_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_rspv_%0d", i), 32'(r1_rsp_valid), 32'd1);
            chk($sformatf("bp_data_%0d", i), r1_rsp_data, 32'd1);
            chk($sformatf("bp_r0rdy_%0d", i), 32'(r0_ready), 32'd0);
            tick();
        end
        r1_rsp_ready = 1'b1;
        #1;
        chk("bp_rise_r0rdy", 32'(r0_ready), 32'd0);
        tick();
        chk("bp_after_r0rdy", 32'({r1_ready, r0_ready}), 32'd1);
        tick();
        r0_valid = 1'b0;
        tick();
        chk("bp_r0_data", r0_rsp_data, 32'd8);
        tick();
        chk("bp_count", 32'(op_count), 32'd10);

        // Reset during EXEC drops the transaction
        r0_op = 4'd0; r0_a = 32'd9; r0_b = 32'd9; r0_valid = 1'b1;
        tick();
        r0_valid = 1'b0;
        chk("rx_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rx_busy", 32'(busy), 32'd0);
        chk("rx_alu", alu_a | alu_b | 32'(alu_op), 32'd0);
        chk("rx_count", 32'(op_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rx_rspv_%0d", i), 32'({r1_rsp_valid, r0_rsp_valid}), 32'd0);
            tick();
        end
        run_txn(1, 4'd4, 32'hFF, 32'h0F, 32'hF0, "rx_next");
        chk("rx_next_count", 32'(op_count), 32'd1);

        // Undecoded op code passes through
        run_txn(0, 4'hF, 32'd1, 32'd1, 32'hDEAD_BEEF, "unk");
        chk("unk_alu_op", 32'(alu_op), 32'hF);

        // Counter wrap
        force dut.op_count_reg = 16'hFFFF;
        #1;
        release dut.op_count_reg;
        #1;
        chk("wrap_pre", 32'(op_count), 32'hFFFF);
        @(negedge clk);
        run_txn(0, 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, "wrap");
        chk("wrap_post", 32'(op_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
